dmem_uart_bridge: RTL and testbench

- Data-side memory subsystem directly downstream of the single-cycle processor.
- Consumes we, address_to_mem and data_to_mem, and returns data_from_mem combinationally in the same cycle.
- Decodes the address into a word RAM, a memory-mapped UART transmitter with a TX FIFO, and a free-running cycle counter.
- Gives test programs a byte-serial output channel.

---
 rtl/dmem_uart_bridge_if.sv | 10 +
 rtl/dmem_uart_bridge.sv | 175 +++++++++++++++++
 tb/tb_dmem_uart_bridge.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_uart_bridge_if.sv
// Processor data-side bus: store strobe, address, store data and combinational load data.
interface dmem_uart_bridge_if;
  logic        we;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic [31:0] data_from_mem;

  modport master (output we, address_to_mem, data_to_mem, input data_from_mem);
  modport slave  (input we, address_to_mem, data_to_mem, output data_from_mem);
endinterface

// File: rtl/dmem_uart_bridge.sv
// Data memory subsystem: word RAM, memory-mapped UART transmitter with TX FIFO,
// and a free-running cycle counter, all behind one combinational-read bus.
module dmem_uart_bridge #(
  parameter int unsigned RAM_WORDS    = 1024,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_uart_bridge_if.slave    bus,
  output logic                 uart_tx,
  output logic                 tx_irq
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [29:0] TXDATA_WA = 30'h3FFF_FFC0;
  localparam logic [29:0] STATUS_WA = 30'h3FFF_FFC1;
  localparam logic [29:0] CYCLES_WA = 30'h3FFF_FFC2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [31:0]       ram      [RAM_WORDS];
  logic [7:0]        fifo_mem [FIFO_DEPTH];

  state_e            state_q,  state_d;
  logic [BAUD_W-1:0] baud_q,   baud_d;
  logic [2:0]        bit_q,    bit_d;
  logic [7:0]        shift_q,  shift_d;
  logic              tx_q,     tx_d;
  logic              irq_q,    irq_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              ovf_q,    ovf_d;
  logic [31:0]       cycles_q, cycles_d;

  logic              ram_hit, is_tx, is_status, is_cycles;
  logic              full, empty, busy, push, pop, baud_last;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       rdata;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^bus.address_to_mem[1:0];

  // Address decode (byte offset within a word is ignored)
  assign ram_hit   = (bus.address_to_mem[31:RAM_AW+2] == '0);
  assign ram_idx   = bus.address_to_mem[RAM_AW+1:2];
  assign is_tx     = (bus.address_to_mem[31:2] == TXDATA_WA);
  assign is_status = (bus.address_to_mem[31:2] == STATUS_WA);
  assign is_cycles = (bus.address_to_mem[31:2] == CYCLES_WA);

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign busy      = (state_q != IDLE);
  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    rdata = '0;
    if (ram_hit)        rdata = ram[ram_idx];
    else if (is_status) rdata = {24'h0, 4'(count_q), ovf_q, empty, full, busy};
    else if (is_cycles) rdata = cycles_q;
  end

  assign bus.data_from_mem = rdata;

  // RAM and FIFO storage carry no reset
  always_ff @(posedge clk) begin
    if (bus.we && ram_hit) ram[ram_idx] <= bus.data_to_mem;
    if (push)              fifo_mem[wr_ptr_q] <= bus.data_to_mem[7:0];
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    pop      = 1'b0;
    cycles_d = cycles_q + 32'd1;
    push     = bus.we && is_tx && !full;

    // Overflow set is applied last so it dominates a clear
    if (bus.we && is_status && bus.data_to_mem[3]) ovf_d = 1'b0;
    if (bus.we && is_tx && full)                   ovf_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          bit_d   = '0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Line level follows the next state so uart_tx comes straight from a flop
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    irq_d = (count_d == '0) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cycles_q <= cycles_d;
    end
  end

  assign uart_tx = tx_q;
  assign tx_irq  = irq_q;

endmodule

// File: tb/tb_dmem_uart_bridge.sv
// Scoreboard bench for dmem_uart_bridge: a transaction-level model predicts loads,
// STATUS and tx_irq per cycle, and the bytes each UART frame must carry.
module tb_dmem_uart_bridge;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RW    = 64;
  localparam logic [31:0] A_TX  = 32'hFFFF_FF00;
  localparam logic [31:0] A_ST  = 32'hFFFF_FF04;
  localparam logic [31:0] A_CY  = 32'hFFFF_FF08;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic uart_tx, tx_irq;

  dmem_uart_bridge_if bus ();

  dmem_uart_bridge #(.RAM_WORDS(RW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .bus(bus), .uart_tx(uart_tx), .tx_irq(tx_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // Reference model: RAM contents, FIFO queue, frames owed on the line
  logic [31:0] ram_m [int];
  logic [7:0]  mq[$];
  logic [7:0]  sent_q[$];
  logic        ovf_m;
  logic [31:0] cyc_m;
  int          ecnt, busy_end;

  function automatic void model_reset();
    mq.delete();
    sent_q.delete();
    ovf_m    = 1'b0;
    cyc_m    = '0;
    ecnt     = 0;
    busy_end = -1;
  endfunction

  function automatic logic model_busy();
    return ecnt <= busy_end;
  endfunction

  function automatic logic model_irq();
    return (mq.size() == 0) && !model_busy();
  endfunction

  function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    v  = '0;
    if (a < 32'(RW * 4)) begin
      if (!ram_m.exists(int'(a >> 2))) return 1'b0;
      v = ram_m[int'(a >> 2)];
    end else if (wa == A_ST) begin
      v = {24'h0, 4'(mq.size()), ovf_m, mq.size() == 0, mq.size() == int'(DEPTH), model_busy()};
    end else if (wa == A_CY) begin
      v = cyc_m;
    end
    return 1'b1;
  endfunction

  // One clock edge: a transmitter that is idle takes the head, then the store lands
  function automatic void model_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
    int pre;
    logic [31:0] wa;
    pre = mq.size();
    wa  = {a[31:2], 2'b00};
    if (ecnt > busy_end && pre > 0) begin
      sent_q.push_back(mq.pop_front());
      busy_end = ecnt + int'(10 * CPB);
    end
    if (w) begin
      if (a < 32'(RW * 4))  ram_m[int'(a >> 2)] = d;
      else if (wa == A_TX) begin
        if (pre < int'(DEPTH)) mq.push_back(d[7:0]);
        else                   ovf_m = 1'b1;
      end else if (wa == A_ST && d[3]) ovf_m = 1'b0;
    end
    cyc_m = cyc_m + 32'd1;
    ecnt++;
  endfunction

  typedef struct {
    string       nm;
    bit          chk_d;
    logic [31:0] d;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];

  // Drive one bus cycle just after a rising edge; expectations go to the scoreboard
  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d, input string nm);
    exp_t e;
    logic [31:0] v;
    bus.we             = w;
    bus.address_to_mem = a;
    bus.data_to_mem    = d;
    e.nm    = nm;
    e.chk_d = model_read(a, v);
    e.d     = v;
    e.irq   = model_irq();
    exp_q.push_back(e);
    @(posedge clk);
    if (reset) model_edge(w, a, d);
    #1;
  endtask

  task automatic idle(input int n, input logic [31:0] a);
    repeat (n) step(1'b0, a, '0, "idle_rd");
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_async_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_async_irq", 32'(tx_irq), 32'd1);
    step(1'b0, A_ST, '0, "rst_status");
    step(1'b0, A_CY, '0, "rst_cycles");
    reset = 1'b1;
  endtask

  // Bus monitor: compare load data and tx_irq mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.nm, "_irq"}, 32'(tx_irq), 32'(e.irq));
      if (e.chk_d) chk(e.nm, bus.data_from_mem, e.d);
    end
  end

  // Line monitor: every sample of a frame must match start/data/stop for the owed byte
  bit          mon_active = 1'b0;
  bit          mon_done   = 1'b0;
  logic        mon_prev   = 1'b1;
  int          mon_idx, mon_bad_samp;
  logic [7:0]  mon_exp, mon_rx;

  always @(negedge clk) begin
    if (!reset) begin
      mon_active = 1'b0;
      mon_done   = 1'b0;
      mon_prev   = 1'b1;
    end else begin
      if (mon_done) begin
        chk("uart_gap_idle", 32'(uart_tx), 32'd1);
        mon_done = 1'b0;
      end
      if (!mon_active) begin
        if (uart_tx === 1'b0 && mon_prev === 1'b1) begin
          if (sent_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL uart_unexpected_frame: got start bit want idle line");
          end else begin
            mon_exp      = sent_q.pop_front();
            mon_active   = 1'b1;
            mon_idx      = 1;
            mon_bad_samp = 0;
            mon_rx       = '0;
          end
        end
      end else begin
        int k;
        logic eb;
        k  = mon_idx / int'(CPB);
        eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : mon_exp[k-1];
        if (uart_tx !== eb) mon_bad_samp++;
        if (k >= 1 && k <= 8 && (mon_idx % int'(CPB)) == int'(CPB / 2)) mon_rx[k-1] = uart_tx;
        mon_idx++;
        if (mon_idx == int'(10 * CPB)) begin
          chk("uart_byte", 32'(mon_rx), 32'(mon_exp));
          chk("uart_shape", 32'(mon_bad_samp), 32'd0);
          mon_active = 1'b0;
          mon_done   = 1'b1;
        end
      end
      mon_prev = uart_tx;
    end
  end

  logic [31:0] um [4];

  initial begin
    um[0] = 32'h8000_0000;
    um[1] = 32'hFFFF_FF0C;
    um[2] = 32'(RW * 4);
    um[3] = 32'hFFFF_FEFC;
    bus.we = 1'b0;
    bus.address_to_mem = '0;
    bus.data_to_mem = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    step(1'b0, A_ST, '0, "rst_status");
    step(1'b0, A_CY, '0, "rst_cycles");
    reset = 1'b1;

    // RAM: basic store/load, byte-offset aliasing, top-of-range boundary
    step(1'b1, 32'h0000_0010, 32'h1234_5678, "ram_wr");
    step(1'b0, 32'h0000_0010, '0, "ram_rd");
    step(1'b1, 32'h0000_0017, 32'hCAFE_F00D, "ram_wr_lsb");
    step(1'b0, 32'h0000_0014, '0, "ram_rd_lsb");
    step(1'b1, 32'h0000_0000, 32'h0BAD_F00D, "ram_wr0");
    step(1'b1, 32'(RW * 4 - 4), 32'hA5A5_0001, "ram_wr_top");
    step(1'b1, 32'(RW * 4), 32'hFFFF_0BAD, "ram_wr_oob");
    step(1'b0, 32'(RW * 4), '0, "oob_rd");
    step(1'b0, 32'(RW * 4 - 4), '0, "ram_rd_top");

    // Single frame of 0x55
    step(1'b1, A_TX, 32'h0000_0055, "tx_55");
    idle(45, A_ST);

    // Five back-to-back pushes all accepted, six more overflow, then clear
    for (int i = 0; i < 5; i++) step(1'b1, A_TX, 32'h41 + 32'(i), "tx_burst");
    for (int i = 0; i < 6; i++) step(1'b1, A_TX, 32'h46 + 32'(i), "tx_ovf");
    step(1'b0, A_ST, '0, "status_ovf");
    step(1'b1, A_ST, 32'h8, "status_clr");
    step(1'b0, A_ST, '0, "status_after_clr");
    idle(5 * 41 + 10, A_ST);

    // Cycle counter: spacing, read-only, wrap
    step(1'b0, A_CY, '0, "cyc_a");
    idle(99, 32'h0000_0010);
    step(1'b1, A_CY, 32'h0000_1234, "cyc_b_wr");
    step(1'b0, A_CY, '0, "cyc_after_wr");
    force dut.cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycles_q;
    cyc_m = 32'hFFFF_FFFE;
    repeat (3) step(1'b0, A_CY, '0, "cyc_wrap");

    // Reset in the middle of data bit 3
    step(1'b1, A_TX, 32'h0000_00A5, "tx_a5");
    idle(18, A_ST);
    apply_reset();
    step(1'b0, 32'h0000_0014, '0, "ram_kept");
    idle(60, A_ST);

    // Unmapped store has no side effects
    step(1'b1, 32'h8000_0000, 32'hDEAD_BEEF, "um_wr");
    step(1'b0, 32'h8000_0000, '0, "um_rd");
    step(1'b0, 32'h0000_0000, '0, "ram0_kept");
    step(1'b0, A_ST, '0, "um_status");

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      int op;
      logic [31:0] d, lo;
      op = int'($urandom_range(0, 11));
      d  = $urandom;
      lo = 32'($urandom_range(0, 3));
      case (op)
        0, 1, 2: step(1'b1, (32'($urandom_range(0, 15)) << 2) | lo, d, "rnd_ram_wr");
        3, 4, 5: step(1'b0, (32'($urandom_range(0, 15)) << 2) | lo, d, "rnd_ram_rd");
        6:       step(1'b1, A_TX | lo, d, "rnd_tx_wr");
        7:       step(1'($urandom_range(0, 1)), A_ST | lo, d, "rnd_status");
        8:       step(1'($urandom_range(0, 1)), A_CY | lo, d, "rnd_cycles");
        9:       step(1'($urandom_range(0, 1)), um[$urandom_range(0, 3)], d, "rnd_unmapped");
        default: step(1'b0, A_TX, d, "rnd_tx_rd");
      endcase
    end
    idle(DEPTH * 41 + 60, A_ST);

    chk("frames_drained", 32'(sent_q.size()), 32'd0);
    chk("line_monitor_idle", 32'(mon_active), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
